// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-16 Booth sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFinal,
    StDone
  } state_e;

  // Number of radix-16 Booth digits covering a width-bit operand plus its sign position.
  function automatic int unsigned calc_ndig(input int unsigned width);
    return (width + 4) / 4;
  endfunction

endpackage

// File: rtl/radix16_digit_sel.sv
// Radix-16 Booth digit recoder: turns a 5-bit overlapping window of the multiplier into a
// selected multiple of the multiplicand (complemented when the digit is negative) and a
// negate flag. The caller injects the +1 that completes the two's complement.
module radix16_digit_sel #(
  parameter int unsigned MW = 27
) (
  input  logic [4:0]          window,
  input  logic [8:0][MW-1:0]  mults,
  output logic [MW-1:0]       pp,
  output logic                neg
);

  logic [3:0]    low_val;
  logic [3:0]    mag;
  logic [MW-1:0] sel;

  // Digit = -8*w4 + 4*w3 + 2*w2 + w1 + w0; pick |digit| * a and complement if negative.
  always_comb begin
    low_val = {1'b0, window[3:1]} + {3'b000, window[0]};
    mag     = window[4] ? (4'd8 - low_val) : low_val;
    // A window of all ones is digit zero; keep it positive so no stray +1 is injected.
    neg     = window[4] && (mag != 4'd0);
    sel     = '0;
    case (mag)
      4'd0:    sel = mults[0];
      4'd1:    sel = mults[1];
      4'd2:    sel = mults[2];
      4'd3:    sel = mults[3];
      4'd4:    sel = mults[4];
      4'd5:    sel = mults[5];
      4'd6:    sel = mults[6];
      4'd7:    sel = mults[7];
      4'd8:    sel = mults[8];
      default: sel = '0;
    endcase
    pp = neg ? ~sel : sel;
  end

endmodule

// File: rtl/radix16_booth_seq_mul.sv
// Sequential radix-16 Booth multiplier: one digit partial product per cycle into a
// carry-save accumulator, then a single carry-propagate add. Latency NDIG+1 cycles from
// accept to out_valid.
// Build option: define MUL_SIGNED_EN to add the in_signed port (per-operation signed mode);
// without it all operands are unsigned.
module radix16_booth_seq_mul
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
`ifdef MUL_SIGNED_EN
  input  logic                 in_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product
);

  localparam int unsigned NDIG = calc_ndig(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;        // product / accumulator width
  localparam int unsigned MW   = WIDTH + 3;        // width of the stored multiples 0..8
  localparam int unsigned BW   = 4 * NDIG;         // recoded multiplier width
  localparam int unsigned CW   = $clog2(NDIG + 1);

  state_e                 state;
  logic [CW-1:0]          cnt;
  logic [PW-1:0]          sum_q;
  logic [PW-1:0]          carry_q;
  logic [8:0][MW-1:0]     mults_q;
  logic [BW:0]            bx_q;      // extended multiplier with the implicit 0 below bit 0
  logic                   sgn_q;

  logic                   sgn_in;
  logic [MW-1:0]          a_ext;
  logic [BW-1:0]          b_ext;
  logic [8:0][MW-1:0]     mults_d;
  logic [4:0]             window;
  logic [MW-1:0]          sel_pp;
  logic                   sel_neg;
  logic                   fill;
  logic [PW-1:0]          pp_ext;
  logic [PW-1:0]          s_in;
  logic [PW-1:0]          c_in;
  logic [PW-1:0]          csa_sum;
  logic [PW-1:0]          csa_carry;

`ifdef MUL_SIGNED_EN
  assign sgn_in = in_signed;
`else
  assign sgn_in = 1'b0;
`endif

  assign in_ready = (state == StIdle);

  // Operand extension and the multiple table 0..8 of the multiplicand.
  always_comb begin
    a_ext = {{3{sgn_in & in_a[WIDTH-1]}}, in_a};
    b_ext = {{(BW - WIDTH){sgn_in & in_b[WIDTH-1]}}, in_b};
    for (int k = 0; k < 9; k++) begin
      mults_d[k] = a_ext * MW'(k);
    end
  end

  // Digits are consumed most-significant first; the top window of the shift register.
  assign window = bx_q[BW -: 5];

  radix16_digit_sel #(
    .MW (MW)
  ) u_digit_sel (
    .window (window),
    .mults  (mults_q),
    .pp     (sel_pp),
    .neg    (sel_neg)
  );

  // Horner-style carry-save step: acc = 16*acc + pp + neg. Shifting both words left by four
  // leaves carry bit 0 free, which is exactly where the negation +1 belongs.
  always_comb begin
    fill      = sgn_q ? sel_pp[MW-1] : sel_neg;
    pp_ext    = {{(PW - MW){fill}}, sel_pp};
    s_in      = {sum_q[PW-5:0], 4'b0000};
    c_in      = {carry_q[PW-5:0], 3'b000, sel_neg};
    csa_sum   = s_in ^ c_in ^ pp_ext;
    csa_carry = ((s_in & c_in) | (s_in & pp_ext) | (c_in & pp_ext)) << 1;
  end

  // Control FSM plus datapath registers; outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      cnt         <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      mults_q     <= '0;
      bx_q        <= '0;
      sgn_q       <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            mults_q <= mults_d;
            bx_q    <= {b_ext, 1'b0};
            sgn_q   <= sgn_in;
            sum_q   <= '0;
            carry_q <= '0;
            cnt     <= '0;
            state   <= StCalc;
          end
        end
        StCalc: begin
          sum_q   <= csa_sum;
          carry_q <= csa_carry;
          bx_q    <= {bx_q[BW-4:0], 4'b0000};
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(NDIG - 1)) begin
            state <= StFinal;
          end
        end
        StFinal: begin
          out_product <= sum_q + carry_q;
          out_valid   <= 1'b1;
          state       <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_radix16_booth_seq_mul.sv
// Scoreboard bench for radix16_booth_seq_mul: a WIDTH=24 instance with random backpressure
// and a WIDTH=8 instance; expected products come from plain integer multiplication.
module tb_radix16_booth_seq_mul;

  localparam int NDIG24 = 7;
  localparam int NDIG8  = 3;

  typedef struct {
    logic [47:0] p;
    int          acc;
  } exp24_t;

  typedef struct {
    logic [15:0] p;
    int          acc;
  } exp8_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_a = '0;
  logic [23:0] in_b = '0;
`ifdef MUL_SIGNED_EN
  logic        in_signed = 1'b0;
  logic        in_signed8 = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_product;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  in_a8 = '0;
  logic [7:0]  in_b8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [15:0] out_product8;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  bit          hold_low = 1'b0;
  bit          bp_on = 1'b0;
  bit          pending = 1'b0;
  logic [47:0] held;
  exp24_t      q[$];
  exp8_t       q8[$];

  radix16_booth_seq_mul #(.WIDTH(24)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
`ifdef MUL_SIGNED_EN
    .in_signed   (in_signed),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  radix16_booth_seq_mul #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid8),
    .in_ready    (in_ready8),
    .in_a        (in_a8),
    .in_b        (in_b8),
`ifdef MUL_SIGNED_EN
    .in_signed   (in_signed8),
`endif
    .out_valid   (out_valid8),
    .out_ready   (out_ready8),
    .out_product (out_product8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer readiness changes just after the rising edge so it is stable at the falling edge.
  always @(posedge clk) begin
    #2;
    if (hold_low)   out_ready = 1'b0;
    else if (bp_on) out_ready = ($urandom_range(0, 2) != 0);
    else            out_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [47:0] ref24(input logic [23:0] a, input logic [23:0] b,
                                        input bit s);
    longint      pa;
    longint      pb;
    logic [63:0] r;
    pa = s ? longint'($signed(a)) : longint'({40'd0, a});
    pb = s ? longint'($signed(b)) : longint'({40'd0, b});
    r  = pa * pb;
    return r[47:0];
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input bit s);
    int          pa;
    int          pb;
    logic [31:0] r;
    pa = s ? int'($signed(a)) : int'({24'd0, a});
    pb = s ? int'($signed(b)) : int'({24'd0, b});
    r  = pa * pb;
    return r[15:0];
  endfunction

  task automatic issue(input logic [23:0] a, input logic [23:0] b, input bit s);
    int     n;
    bit     ok;
    exp24_t e;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
`ifdef MUL_SIGNED_EN
    in_signed = s;
`endif
    while (!ok && n < 100) begin
      if (in_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (ok) begin
      e.p   = ref24(a, b, s);
      e.acc = cyc + 1;
      q.push_back(e);
      @(negedge clk);
    end else begin
      chk("accept_timeout24", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit s);
    int    n;
    bit    ok;
    exp8_t e;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b1;
    in_a8     = a;
    in_b8     = b;
`ifdef MUL_SIGNED_EN
    in_signed8 = s;
`endif
    while (!ok && n < 100) begin
      if (in_ready8) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (ok) begin
      e.p   = ref8(a, b, s);
      e.acc = cyc + 1;
      q8.push_back(e);
      @(negedge clk);
    end else begin
      chk("accept_timeout8", 64'd0, 64'd1);
    end
    in_valid8 = 1'b0;
  endtask

  // Monitor for the 24-bit instance: compare on first sight of each result, then watch it hold.
  always @(negedge clk) begin
    exp24_t e;
    if (!rst_n) begin
      q.delete();
      pending = 1'b0;
    end else if (out_valid) begin
      if (!pending) begin
        if (q.size() == 0) begin
          chk("spurious_valid24", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("product24", 64'(out_product), 64'(e.p));
          chk("latency24", 64'(cyc - e.acc), 64'(NDIG24 + 1));
          held    = out_product;
          pending = 1'b1;
        end
      end else begin
        chk("hold24", 64'(out_product), 64'(held));
      end
      if (out_ready) pending = 1'b0;
    end else if (pending) begin
      chk("valid_dropped24", 64'd0, 64'd1);
      pending = 1'b0;
    end
  end

  // Monitor for the 8-bit instance (always ready, so each result is a one-cycle pulse).
  always @(negedge clk) begin
    exp8_t e;
    if (!rst_n) begin
      q8.delete();
    end else if (out_valid8) begin
      if (q8.size() == 0) begin
        chk("spurious_valid8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        chk("product8", 64'(out_product8), 64'(e.p));
        chk("latency8", 64'(cyc - e.acc), 64'(NDIG8 + 1));
      end
    end
  end

  function automatic logic [23:0] pick24();
    case ($urandom_range(0, 7))
      0:       return 24'h000000;
      1:       return 24'hFFFFFF;
      2:       return 24'h800000;
      3:       return 24'h7FFFFF;
      4:       return 24'h000001;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || pending || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain24", 64'(q.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);
  endtask

  initial begin
    bit s;
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_product", 64'(out_product), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed boundary operands.
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    issue(24'h000000, 24'hFFFFFF, 1'b0);
    issue(24'hFFFFFF, 24'h000000, 1'b0);
    issue(24'h800000, 24'h800000, 1'b0);
    issue(24'h123456, 24'h000001, 1'b0);
`ifdef MUL_SIGNED_EN
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b1);
    issue(24'h800000, 24'h7FFFFF, 1'b1);
    issue(24'h800000, 24'h800000, 1'b1);
`endif
    drain();
    chk("known_full_scale", 64'(ref24(24'hFFFFFF, 24'hFFFFFF, 1'b0)), 64'hFFFFFE000001);

    // Held result in DONE while a new pair is offered: it must wait and not corrupt.
    hold_low = 1'b1;
    issue(24'hABCDEF, 24'h13579B, 1'b0);
    in_valid = 1'b1;
    in_a     = 24'h2468AC;
    in_b     = 24'hFEDCBA;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached_done", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("busy_in_ready", 64'(in_ready), 64'd0);
    end
    hold_low = 1'b0;
    issue(24'h2468AC, 24'hFEDCBA, 1'b0);
    drain();

    // Reset during CALC cycle 3: operation is discarded, no output follows.
    issue(24'h654321, 24'h0FEDCB, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_product", 64'(out_product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (NDIG24 + 3) begin
      @(negedge clk);
      chk("post_rst_no_valid", 64'(out_valid), 64'd0);
    end
    issue(24'h00BEEF, 24'h00CAFE, 1'b0);
    drain();

    // Random traffic with backpressure.
    bp_on = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      s = 1'b0;
`ifdef MUL_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`endif
      issue(pick24(), pick24(), s);
    end
    drain();
    bp_on = 1'b0;

    // 8-bit instance.
    issue8(8'h80, 8'h80, 1'b0);
    issue8(8'hFF, 8'hFF, 1'b0);
    issue8(8'h00, 8'hFF, 1'b0);
`ifdef MUL_SIGNED_EN
    issue8(8'h80, 8'h7F, 1'b1);
    issue8(8'hFF, 8'hFF, 1'b1);
`endif
    for (int i = 0; i < 300; i++) begin
      s = 1'b0;
`ifdef MUL_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`endif
      issue8(8'($urandom), 8'($urandom), s);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
